// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_sequencer_pkg : shared types and defaults for the PC sequencer        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pc_sequencer_pkg;

  localparam int PKG_PC_W      = 16;
  localparam int PKG_RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_CALL = 3'd3,
    SEL_RET  = 3'd4
  } sel_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_sequencer_if : decode/execute control in, next-PC and status out      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PKG_PC_W
);
  logic [PC_W-1:0] pc_in;
  logic            instr_valid;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_offset;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic            call;
  logic            ret;
  logic            halt;
  logic [31:0]     next_pc;
  logic            pc_enable;
  logic            flush;
  logic            ras_overflow;
  logic            ras_underflow;

  modport master (
    output pc_in, instr_valid, stall, branch_taken, branch_offset,
           jump, jump_target, call, ret, halt,
    input  next_pc, pc_enable, flush, ras_overflow, ras_underflow
  );

  modport slave (
    input  pc_in, instr_valid, stall, branch_taken, branch_offset,
           jump, jump_target, call, ret, halt,
    output next_pc, pc_enable, flush, ras_overflow, ras_underflow
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer_return_addr_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | return_addr_stack : circular LIFO; a push when full overwrites oldest    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module return_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_top,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_depth = PTR_W'(DEPTH) + (PTR_W+1)'(0) | ((PTR_W+1)'(1) << PTR_W);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_top_idx;

  // r_wr_ptr is the next write slot; once full it also points at the oldest entry
  assign w_top_idx = r_wr_ptr - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_depth);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_pop) begin
      if (!o_empty) begin
        r_wr_ptr <= w_top_idx;
        r_count  <= r_count - (PTR_W+1)'(1);
      end
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
      r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      if (!o_full) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_sequencer : next-PC select, return-address stack and run-control FSM  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int RAS_DEPTH = PKG_RAS_DEPTH,
  parameter int PC_W      = PKG_PC_W
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);
  state_t          r_state;
  state_t          w_state_nxt;
  sel_t            w_sel;
  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_br;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_go;
  logic            w_pc_en;
  logic            w_push;
  logic            w_pop;
  logic            w_redirect;
  logic            r_flush;
  logic            r_ovf;
  logic            r_unf;

  assign w_go    = !reset && (r_state == ST_RUN) && bus.instr_valid && !bus.stall;
  assign w_pc_en = w_go && !bus.halt;
  assign w_seq   = bus.pc_in + PC_W'(1);
  assign w_br    = w_seq + bus.branch_offset;

  always_comb begin
    w_sel = SEL_SEQ;
    if (bus.ret)               w_sel = SEL_RET;
    else if (bus.call)         w_sel = SEL_CALL;
    else if (bus.jump)         w_sel = SEL_JMP;
    else if (bus.branch_taken) w_sel = SEL_BR;
  end

  always_comb begin
    w_target = w_seq;
    case (w_sel)
      SEL_RET:  w_target = w_ras_empty ? w_seq : w_ras_top;
      SEL_CALL: w_target = bus.jump_target;
      SEL_JMP:  w_target = bus.jump_target;
      SEL_BR:   w_target = w_br;
      default:  w_target = w_seq;
    endcase
  end

  assign w_push     = w_pc_en && (w_sel == SEL_CALL);
  assign w_pop      = w_pc_en && (w_sel == SEL_RET);
  assign w_redirect = w_pc_en && (w_sel != SEL_SEQ);

  return_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_seq),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  if (w_go && bus.halt) w_state_nxt = ST_HALT;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_flush <= w_redirect;
      if (w_push && w_ras_full)  r_ovf <= 1'b1;
      if (w_pop && w_ras_empty)  r_unf <= 1'b1;
    end
  end

  assign bus.next_pc       = {{(32-PC_W){1'b0}}, (w_pc_en ? w_target : bus.pc_in)};
  assign bus.pc_enable     = w_pc_en;
  assign bus.flush         = r_flush;
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_sequencer : directed vectors with a scoreboard queue and monitor   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pc_sequencer;

  typedef struct {
    logic        en;
    logic [31:0] npc;
    logic        fl;
    logic        ov;
    logic        un;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares the DUT outputs against the queued expectation each cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_enable",     {31'd0, bus.pc_enable},     {31'd0, e.en});
      chk("next_pc",       bus.next_pc,                e.npc);
      chk("flush",         {31'd0, bus.flush},         {31'd0, e.fl});
      chk("ras_overflow",  {31'd0, bus.ras_overflow},  {31'd0, e.ov});
      chk("ras_underflow", {31'd0, bus.ras_underflow}, {31'd0, e.un});
    end
  end

  task automatic idle(input logic [15:0] pc);
    reset             = 1'b0;
    bus.pc_in         = pc;
    bus.instr_valid   = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 16'h0000;
    bus.jump          = 1'b0;
    bus.jump_target   = 16'h0000;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
    bus.halt          = 1'b0;
  endtask

  task automatic cyc(input logic en, input logic [31:0] npc, input logic fl,
                     input logic ov, input logic un);
    exp_t e;
    e.en = en; e.npc = npc; e.fl = fl; e.ov = ov; e.un = un;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(16'h0005);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset held: BOOT, everything cleared
    idle(16'h0005); reset = 1'b1;           cyc(0, 32'h5, 0, 0, 0);
    // boot cycle then first update
    idle(16'h0000);                         cyc(0, 32'h0, 0, 0, 0);
    idle(16'h0000);                         cyc(1, 32'h1, 0, 0, 0);

    // branch wrap and flush for exactly one cycle
    idle(16'hFFFE); bus.branch_taken = 1; bus.branch_offset = 16'h0003;
                                            cyc(1, 32'h2, 0, 0, 0);
    idle(16'h0002);                         cyc(1, 32'h3, 1, 0, 0);
    idle(16'h0003);                         cyc(1, 32'h4, 0, 0, 0);

    // negative branch, then invalid instruction with flush still shown
    idle(16'h0010); bus.branch_taken = 1; bus.branch_offset = 16'hFFF0;
                                            cyc(1, 32'h1, 0, 0, 0);
    idle(16'h0001); bus.instr_valid = 0;    cyc(0, 32'h1, 1, 0, 0);

    // plain jump
    idle(16'h0001); bus.jump = 1; bus.jump_target = 16'h1234;
                                            cyc(1, 32'h1234, 0, 0, 0);

    // five calls: fifth overwrites the oldest
    idle(16'd10); bus.call = 1; bus.jump_target = 16'h0200; cyc(1, 32'h200, 1, 0, 0);
    idle(16'd20); bus.call = 1; bus.jump_target = 16'h0200; cyc(1, 32'h200, 1, 0, 0);
    idle(16'd30); bus.call = 1; bus.jump_target = 16'h0200; cyc(1, 32'h200, 1, 0, 0);
    idle(16'd40); bus.call = 1; bus.jump_target = 16'h0200; cyc(1, 32'h200, 1, 0, 0);
    idle(16'd50); bus.call = 1; bus.jump_target = 16'h0200; cyc(1, 32'h200, 1, 0, 0);

    // four returns 51,41,31,21 then an empty return
    idle(16'h0300); bus.ret = 1;            cyc(1, 32'd51, 1, 1, 0);
    idle(16'h0301); bus.ret = 1;            cyc(1, 32'd41, 1, 1, 0);
    idle(16'h0302); bus.ret = 1;            cyc(1, 32'd31, 1, 1, 0);
    idle(16'h0303); bus.ret = 1;            cyc(1, 32'd21, 1, 1, 0);
    idle(16'h0400); bus.ret = 1;            cyc(1, 32'h401, 1, 1, 0);
    idle(16'h0401);                         cyc(1, 32'h402, 1, 1, 1);
    idle(16'h0402);                         cyc(1, 32'h403, 0, 1, 1);

    // build RAS: 0x0051 below, 0x0100 on top
    idle(16'h0050); bus.call = 1; bus.jump_target = 16'h0600; cyc(1, 32'h600, 0, 1, 1);
    idle(16'h00FF); bus.call = 1; bus.jump_target = 16'h0500; cyc(1, 32'h500, 1, 1, 1);

    // stalled call+ret+jump: nothing happens, no flush afterwards
    idle(16'h0500); bus.call = 1; bus.ret = 1; bus.jump = 1; bus.jump_target = 16'h0700;
    bus.stall = 1;                          cyc(0, 32'h500, 1, 1, 1);
    idle(16'h0500); bus.call = 1; bus.ret = 1; bus.jump = 1; bus.jump_target = 16'h0700;
                                            cyc(1, 32'h100, 0, 1, 1);
    // only one pop, no push: next return yields the lower entry
    idle(16'h0100); bus.ret = 1;            cyc(1, 32'h51, 1, 1, 1);
    idle(16'h0051); bus.ret = 1;            cyc(1, 32'h52, 1, 1, 1);
    idle(16'h0052);                         cyc(1, 32'h53, 1, 1, 1);

    // halt beats jump; stays halted
    idle(16'h0053); bus.halt = 1; bus.jump = 1; bus.jump_target = 16'h0700;
                                            cyc(0, 32'h53, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      idle(16'h0053); bus.jump = 1; bus.jump_target = 16'h0700;
                                            cyc(0, 32'h53, 0, 1, 1);
    end
    idle(16'h0053); reset = 1'b1;           cyc(0, 32'h53, 0, 1, 1);
    idle(16'h0000);                         cyc(0, 32'h0, 0, 0, 0);
    idle(16'h0000);                         cyc(1, 32'h1, 0, 0, 0);

    // reset discards a pending flush
    idle(16'h0001); bus.jump = 1; bus.jump_target = 16'h0040;
                                            cyc(1, 32'h40, 0, 0, 0);
    idle(16'h0040); reset = 1'b1;           cyc(0, 32'h40, 1, 0, 0);
    idle(16'h0040);                         cyc(0, 32'h40, 0, 0, 0);
    idle(16'h0040);                         cyc(1, 32'h41, 0, 0, 0);

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC generator and PC-update sequencer feeding `Program_counter`: drives its `mux_output` and `pc_enable` inputs from the current `pc_out` and decode/execute control. It selects among sequential, branch, jump, call and return targets. It keeps a 4-entry return-address stack (RAS) and a small run-control FSM (boot, run, halt), and raises a one-cycle flush after every redirect.

## Interface
Parameters:
- `RAS_DEPTH`, 4: return-address stack entries (power of two, ≥2)
- `PC_W`, 16: architectural PC width

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `pc_in`  in  16  current PC (from `pc_out`)
- `instr_valid`  in  1  instruction at `pc_in` is valid this cycle
- `stall`  in  1  hold PC; no state change
- `branch_taken`  in  1  conditional branch resolved taken
- `branch_offset`  in  16  signed word offset
- `jump`  in  1  absolute jump
- `jump_target`  in  16  absolute target
- `call`  in  1  jump to `jump_target` and push return address
- `ret`  in  1  pop RAS and jump to popped address
- `halt`  in  1  halt instruction decoded
- `next_pc`  out  32  to `mux_output`; bits [31:16] always 0
- `pc_enable`  out  1  to `Program_counter`
- `flush`  out  1  squash the instruction fetched in the previous cycle
- `ras_overflow`  out  1  sticky
- `ras_underflow`  out  1  sticky

## Operation
- Control inputs are qualified by `go = state==RUN && instr_valid && !stall`. When `go`=0, control inputs are ignored.
- `seq = pc_in + 1`, mod 2^16. The PC is word-addressed.
- Target priority: ret > call > jump > branch_taken > seq.
  - ret → RAS top; on an empty RAS use `seq` and set `ras_underflow`.
  - call and jump → `jump_target`.
  - branch → `seq + branch_offset` (sign-extended, mod 2^16, wraps silently).
- `call` together with `ret` is treated as `ret` only. No push occurs.
- `call` pushes `seq`. When the RAS is full, the push overwrites the oldest entry (circular), the count stays at `RAS_DEPTH`, and `ras_overflow` is set.
- `ret` pops. An empty pop leaves the pointers unchanged.
- Redirect means any of ret, call, jump or branch_taken selected while `go`=1.
- FSM:
  - BOOT → RUN after one cycle.
  - RUN → HALT when `go` && `halt`. `halt` has priority over all targets; no redirect or push occurs.
  - HALT stays in HALT until `reset`.
- `pc_enable` = `go` && !`halt`.
- `next_pc` is combinational and equals the selected target whenever `pc_enable`=1. Otherwise it equals `{16'b0, pc_in}`.

## Timing
- Reset values (cycle after the `reset` edge):
  - state = BOOT
  - `pc_enable` = 0, `flush` = 0
  - `next_pc` = {16'b0, pc_in}
  - RAS count = 0
  - `ras_overflow` = 0, `ras_underflow` = 0
- BOOT lasts exactly 1 cycle. The first possible PC update is at the end of the 2nd cycle after reset deasserts.
- Next-PC path is 0 cycles (combinational). `Program_counter` captures the target at the same edge.
- `flush` is registered: high exactly in cycle N+1 after a redirect in cycle N, then low. It is unaffected by `stall` in N+1.
- RAS push/pop and sticky flags update at the same edge as the PC.
- `stall`=1 freezes the PC, RAS and flags, and generates no flush.
- `reset` mid-operation overrides everything in that cycle and discards pending flush, RAS contents and HALT.

## Structure
- Shared package holds:
  - FSM state enum (BOOT, RUN, HALT)
  - `PC_W`
  - `RAS_DEPTH` default
  - target-select encoding (SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET)
- One sub-module, `return_addr_stack`: circular LIFO with push, pop, top, empty, full and overflow-on-push.
- Target mux, adders and FSM stay in the top module.

## Test plan
- **Reset/boot:** assert `reset`, release; `pc_in`=0, `instr_valid`=1 → cycle 1 `pc_enable`=0; cycle 2 `pc_enable`=1, `next_pc`=1.
- **Branch wrap:** `pc_in`=16'hFFFE, `branch_taken`=1, `branch_offset`=16'h0003 → `next_pc`=32'h0000_0002; `flush`=1 next cycle only.
- **Negative branch:** `pc_in`=16'h0010, offset 16'hFFF0 → `next_pc`=32'h0000_0001.
- **RAS overflow/underflow:**
  - 5 calls from `pc_in`=10,20,30,40,50 → `ras_overflow`=1.
  - 4 rets return 51,41,31,21.
  - 5th ret → `next_pc`=`pc_in`+1 and `ras_underflow`=1.
- **Priority and stall:**
  - `call`+`ret`+`jump` together with RAS top=16'h0100 → `next_pc`=16'h0100, RAS count decremented by 1.
  - Same inputs with `stall`=1 → `pc_enable`=0, RAS unchanged, no `flush`.
- **Halt:** `halt`=1 with `jump`=1 → `pc_enable`=0 that cycle and every cycle after; `flush` stays 0; `reset` returns the block to BOOT.
